control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle control unit for the 16-bit accumulator processor. It decodes the opcode held in the instruction register and sequences the write strobes and multiplexer selects for the datapath registers (PC, IR, ACC) and for data memory. It sits directly upstream of every datapath register instance and drives their write-enable inputs, so a register updates only on the clock edge that this block selects. It also keeps a saturating count of retired instructions for debug.

## Interface
- OPCODE_WIDTH, 5, width of the opcode field taken from the IR
- CNT_WIDTH, 16, width of the retired-instruction counter
- clock  in  1  system clock; all state updates on its rising edge
- cu_reset  in  1  asynchronous, active-high reset
- cu_start  in  1  leave IDLE/HALT and begin fetching
- opcode  in  OPCODE_WIDTH  opcode field of the registered IR output
- acc_zero  in  1  ACC == 0
- acc_neg  in  1  ACC[15]
- ir_wr  out  1  IR write enable
- pc_wr  out  1  PC write enable
- pc_src  out  1  0: PC+1, 1: IR operand
- acc_wr  out  1  ACC write enable
- acc_src  out  2  0: immediate, 1: data memory, 2: ALU result
- alu_op  out  1  0: add, 1: subtract
- alu_b_src  out  1  0: data memory, 1: immediate
- mem_rd  out  1  data memory read request
- mem_wr  out  1  data memory write strobe (stores ACC)
- busy  out  1  1 in every state except IDLE and HALT
- halted  out  1  1 in HALT
- retired_count  out  CNT_WIDTH  instructions completed, saturating

## Operation
- Opcodes: 0x00 HLT, 0x01 STO, 0x02 LD, 0x03 LDI, 0x04 ADD, 0x05 ADDI, 0x06 SUB, 0x07 SUBI, 0x08 JMP, 0x09 BZ, 0x0A BN. All other opcodes execute as NOP (PC+1 only).
- States: IDLE, FETCH, DECODE, EXEC_MEM, HALT.
- IDLE: all strobes 0. cu_start=1 -> FETCH.
- FETCH: ir_wr=1 -> DECODE.
- DECODE, by opcode:
  - HLT -> HALT, no strobes.
  - LD/ADD/SUB: mem_rd=1 -> EXEC_MEM.
  - LDI: acc_wr=1, acc_src=0.
  - ADDI/SUBI: acc_wr=1, acc_src=2, alu_b_src=1, alu_op=0 or 1.
  - STO: mem_wr=1.
  - JMP: pc_src=1.
  - BZ: pc_src=acc_zero.
  - BN: pc_src=acc_neg.
  - NOP: pc_src=0.
  - Every non-HLT, non-memory-read case also asserts pc_wr=1 and goes -> FETCH.
- EXEC_MEM: acc_wr=1, pc_wr=1, pc_src=0.
  - LD: acc_src=1.
  - ADD/SUB: acc_src=2, alu_b_src=0, alu_op per opcode.
  - Then -> FETCH.
- HALT: halted=1, all strobes 0. cu_start=1 -> FETCH, resuming at the current PC (the PC is not advanced past HLT).
- retired_count increments by 1 on each DECODE->FETCH or EXEC_MEM->FETCH transition. It holds at all-ones and never wraps. HLT is not counted.
- Don't-care selects are driven to 0.

## Timing
- State register and retired_count are flip-flops. All other outputs are combinational decodes of the state and opcode; opcode is stable because IR is registered.
- Reset: state=IDLE, retired_count=0; therefore every strobe, busy and halted read 0. Reset takes effect immediately, including mid-instruction. A strobe asserted in the reset cycle is cancelled before the next edge.
- Cycles per instruction: 2 (FETCH, DECODE) for immediate, store, branch and NOP; 3 for LD/ADD/SUB.
- Data memory read latency is 1 cycle: the address is presented with mem_rd in DECODE, and the data is valid in EXEC_MEM.
- cu_start is sampled only in IDLE and HALT and is ignored elsewhere. A level held high simply restarts on the first eligible edge.
- At most one of acc_wr and mem_wr is high in any cycle. ir_wr is never high in the same cycle as pc_wr.
- acc_zero and acc_neg are sampled in DECODE and reflect the ACC value before that instruction.

## Structure
- Shared package cu_pkg holds:
  - the state_t enum;
  - opcode localparams;
  - acc_src encodings (ACC_SRC_IMM, ACC_SRC_MEM, ACC_SRC_ALU);
  - ALU_ADD and ALU_SUB.
- The datapath top imports cu_pkg for the same encodings.
- One sub-module: sat_counter (parameter WIDTH; inputs clock, reset, inc; output count). It implements retired_count.
- The next-state and output decode live in control_unit as one always_ff plus one always_comb.

## Test plan
- Reset then cu_start=1 with opcode=0x03 (LDI): FETCH ir_wr=1; DECODE acc_wr=1, acc_src=0, pc_wr=1, pc_src=0; retired_count=1.
- Opcode 0x04 (ADD): DECODE mem_rd=1 only; EXEC_MEM acc_wr=1, acc_src=2, alu_b_src=0, alu_op=0, pc_wr=1; 3 cycles per instruction.
- Opcode 0x09 (BZ) with acc_zero=1 gives pc_src=1, pc_wr=1; repeat with acc_zero=0 gives pc_src=0. Likewise 0x0A with acc_neg.
- Opcode 0x00 (HLT): HALT reached, halted=1, busy=0, strobes 0 for 10 cycles, count unchanged. cu_start pulse then gives FETCH with ir_wr=1.
- Assert cu_reset during EXEC_MEM: acc_wr drops immediately, state is IDLE, retired_count=0. With CNT_WIDTH=4 and 20 NOPs, count holds at 15.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the accumulator processor control unit and datapath.
// Holds the FSM state type, opcodes, ACC source selects and ALU operations.
package cu_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC_MEM = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_HLT  = 5'h00;
  localparam logic [OP_W-1:0] OP_STO  = 5'h01;
  localparam logic [OP_W-1:0] OP_LD   = 5'h02;
  localparam logic [OP_W-1:0] OP_LDI  = 5'h03;
  localparam logic [OP_W-1:0] OP_ADD  = 5'h04;
  localparam logic [OP_W-1:0] OP_ADDI = 5'h05;
  localparam logic [OP_W-1:0] OP_SUB  = 5'h06;
  localparam logic [OP_W-1:0] OP_SUBI = 5'h07;
  localparam logic [OP_W-1:0] OP_JMP  = 5'h08;
  localparam logic [OP_W-1:0] OP_BZ   = 5'h09;
  localparam logic [OP_W-1:0] OP_BN   = 5'h0A;

  localparam logic [1:0] ACC_SRC_IMM = 2'd0;
  localparam logic [1:0] ACC_SRC_MEM = 2'd1;
  localparam logic [1:0] ACC_SRC_ALU = 2'd2;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam logic PC_SRC_INC = 1'b0;
  localparam logic PC_SRC_IR  = 1'b1;

  localparam logic ALU_B_MEM = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  // Opcodes that need a data-memory read cycle before ACC can be written.
  function automatic logic is_mem_read(input logic [OP_W-1:0] op);
    logic hit;
    case (op)
      OP_LD, OP_ADD, OP_SUB: hit = 1'b1;
      default:               hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used for the retired-instruction debug count.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: async clear, saturating increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 16-bit accumulator processor: sequences
// PC/IR/ACC write enables, datapath selects and data-memory strobes.
module control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    cu_reset,
  input  logic                    cu_start,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    acc_zero,
  input  logic                    acc_neg,
  output logic                    ir_wr,
  output logic                    pc_wr,
  output logic                    pc_src,
  output logic                    acc_wr,
  output logic [1:0]              acc_src,
  output logic                    alu_op,
  output logic                    alu_b_src,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    busy,
  output logic                    halted,
  output logic [CNT_WIDTH-1:0]    retired_count
);

  state_t state_r;
  state_t next_state_s;
  logic   retire_s;

  // Opcodes wider than the defined field with any upper bit set fall to NOP.
  logic [OPCODE_WIDTH+OP_W-1:0] op_ext_s;
  logic                         op_in_range_s;
  logic [OP_W-1:0]              op_s;

  assign op_ext_s      = {{OP_W{1'b0}}, opcode};
  assign op_in_range_s = ((op_ext_s >> OP_W) == '0);
  assign op_s          = op_in_range_s ? op_ext_s[OP_W-1:0] : 5'h1F;

  // State register.
  always_ff @(posedge clock or posedge cu_reset) begin
    if (cu_reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    next_state_s = state_r;
    ir_wr        = 1'b0;
    pc_wr        = 1'b0;
    pc_src       = PC_SRC_INC;
    acc_wr       = 1'b0;
    acc_src      = ACC_SRC_IMM;
    alu_op       = ALU_ADD;
    alu_b_src    = ALU_B_MEM;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    busy         = 1'b1;
    halted       = 1'b0;
    retire_s     = 1'b0;

    case (state_r)
      S_IDLE: begin
        busy = 1'b0;
        if (cu_start) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
      end

      S_FETCH: begin
        ir_wr        = 1'b1;
        next_state_s = S_DECODE;
      end

      S_DECODE: begin
        if (op_s == OP_HLT) begin
          next_state_s = S_HALT;
        end else if (is_mem_read(op_s)) begin
          mem_rd       = 1'b1;
          next_state_s = S_EXEC_MEM;
        end else begin
          pc_wr        = 1'b1;
          retire_s     = 1'b1;
          next_state_s = S_FETCH;
          case (op_s)
            OP_LDI: begin
              acc_wr  = 1'b1;
              acc_src = ACC_SRC_IMM;
            end
            OP_ADDI, OP_SUBI: begin
              acc_wr    = 1'b1;
              acc_src   = ACC_SRC_ALU;
              alu_b_src = ALU_B_IMM;
              alu_op    = (op_s == OP_SUBI) ? ALU_SUB : ALU_ADD;
            end
            OP_STO:  mem_wr = 1'b1;
            OP_JMP:  pc_src = PC_SRC_IR;
            OP_BZ:   pc_src = acc_zero;
            OP_BN:   pc_src = acc_neg;
            default: pc_src = PC_SRC_INC;
          endcase
        end
      end

      S_EXEC_MEM: begin
        acc_wr       = 1'b1;
        pc_wr        = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
        case (op_s)
          OP_ADD: begin
            acc_src = ACC_SRC_ALU;
            alu_op  = ALU_ADD;
          end
          OP_SUB: begin
            acc_src = ACC_SRC_ALU;
            alu_op  = ALU_SUB;
          end
          default: acc_src = ACC_SRC_MEM;
        endcase
      end

      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        // PC was not advanced by HLT, so restart refetches the same address.
        if (cu_start) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_HALT;
        end
      end

      default: begin
        busy         = 1'b0;
        next_state_s = S_IDLE;
      end
    endcase
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_retired (
    .clock (clock),
    .reset (cu_reset),
    .inc   (retire_s),
    .count (retired_count)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit with hand-computed expectations.
module tb_control_unit;

  logic       clock;
  logic       cu_reset;
  logic       cu_start;
  logic [4:0] opcode;
  logic       acc_zero;
  logic       acc_neg;
  logic       ir_wr, pc_wr, pc_src, acc_wr;
  logic [1:0] acc_src;
  logic       alu_op, alu_b_src, mem_rd, mem_wr, busy, halted;
  logic [3:0] retired_count;

  int total;
  int bad;

  control_unit #(
    .OPCODE_WIDTH(5),
    .CNT_WIDTH(4)
  ) dut (
    .clock         (clock),
    .cu_reset      (cu_reset),
    .cu_start      (cu_start),
    .opcode        (opcode),
    .acc_zero      (acc_zero),
    .acc_neg       (acc_neg),
    .ir_wr         (ir_wr),
    .pc_wr         (pc_wr),
    .pc_src        (pc_src),
    .acc_wr        (acc_wr),
    .acc_src       (acc_src),
    .alu_op        (alu_op),
    .alu_b_src     (alu_b_src),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .busy          (busy),
    .halted        (halted),
    .retired_count (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {ir_wr, pc_wr, pc_src, acc_wr, acc_src[1:0], alu_op, alu_b_src, mem_rd, mem_wr}
  function automatic logic [31:0] strobes();
    return {22'd0, ir_wr, pc_wr, pc_src, acc_wr, acc_src, alu_op, alu_b_src, mem_rd, mem_wr};
  endfunction

  function automatic logic [31:0] vec(input logic ir, input logic pw, input logic ps,
                                      input logic aw, input logic [1:0] as, input logic ao,
                                      input logic ab, input logic mr, input logic mw);
    return {22'd0, ir, pw, ps, aw, as, ao, ab, mr, mw};
  endfunction

  initial begin
    total    = 0;
    bad      = 0;
    cu_reset = 1'b1;
    cu_start = 1'b0;
    opcode   = 5'h03;
    acc_zero = 1'b0;
    acc_neg  = 1'b0;
    repeat (3) tick();
    check_eq("reset_strobes", strobes(), 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_halted", {31'd0, halted}, 32'd0);
    check_eq("reset_count", {28'd0, retired_count}, 32'd0);
    cu_reset = 1'b0;
    tick();
    check_eq("idle_strobes", strobes(), 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // LDI
    cu_start = 1'b1;
    tick();
    cu_start = 1'b0;
    #1;
    check_eq("ldi_fetch", strobes(), vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    check_eq("ldi_fetch_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("ldi_decode", strobes(), vec(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    check_eq("ldi_decode_count", {28'd0, retired_count}, 32'd0);
    tick();
    check_eq("ldi_retired", {28'd0, retired_count}, 32'd1);
    check_eq("ldi_next_fetch", {31'd0, ir_wr}, 32'd1);

    // ADD: 3-cycle instruction
    opcode = 5'h04;
    tick();
    check_eq("add_decode", strobes(), vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    check_eq("add_exec", strobes(), vec(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    check_eq("add_exec_count", {28'd0, retired_count}, 32'd1);
    tick();
    check_eq("add_fetch", {31'd0, ir_wr}, 32'd1);
    check_eq("add_retired", {28'd0, retired_count}, 32'd2);

    // BZ taken / not taken, BN taken / not taken
    opcode = 5'h09; acc_zero = 1'b1;
    tick();
    check_eq("bz_taken", strobes(), vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    acc_zero = 1'b0;
    tick();
    check_eq("bz_not_taken", strobes(), vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    opcode = 5'h0A; acc_neg = 1'b1;
    tick();
    check_eq("bn_taken", strobes(), vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    acc_neg = 1'b0;
    tick();
    check_eq("bn_not_taken", strobes(), vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    check_eq("branch_count", {28'd0, retired_count}, 32'd6);

    // SUBI and STO
    opcode = 5'h07;
    tick();
    check_eq("subi_decode", strobes(), vec(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    opcode = 5'h01;
    tick();
    check_eq("sto_decode", strobes(), vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    check_eq("sto_count", {28'd0, retired_count}, 32'd8);

    // HLT: sits in HALT, not counted
    opcode = 5'h00;
    tick();
    check_eq("hlt_decode", strobes(), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("halt_strobes", strobes(), 32'd0);
      check_eq("halt_flags", {30'd0, halted, busy}, 32'd2);
      check_eq("halt_count", {28'd0, retired_count}, 32'd8);
    end
    cu_start = 1'b1;
    tick();
    cu_start = 1'b0;
    #1;
    check_eq("resume_fetch", {30'd0, ir_wr, halted}, 32'd2);

    // SUB interrupted by reset in EXEC_MEM
    opcode = 5'h06;
    tick();
    check_eq("sub_decode", strobes(), vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    check_eq("sub_exec", strobes(), vec(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    cu_reset = 1'b1;
    #1;
    check_eq("midreset_strobes", strobes(), 32'd0);
    check_eq("midreset_busy", {31'd0, busy}, 32'd0);
    check_eq("midreset_count", {28'd0, retired_count}, 32'd0);
    tick();
    cu_reset = 1'b0;
    #1;
    check_eq("after_reset_idle", {30'd0, busy, ir_wr}, 32'd0);

    // 20 NOPs with cu_start held high: count saturates at 15
    opcode   = 5'h1F;
    cu_start = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("nop_decode", strobes(), vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
      check_eq("nop_fetch", {31'd0, ir_wr}, 32'd1);
      check_eq("nop_count", {28'd0, retired_count}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    cu_start = 1'b0;
    check_eq("sat_count", {28'd0, retired_count}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
